image_loader: RTL
=================

IMAGE_LOADER -- requirements
Module: image_loader

Interface
REQ-001 SHALL have parameter IMG_W, default 640, image width in pixels.
REQ-002 SHALL have parameter IMG_H, default 480, image height in rows (memory depth).
REQ-003 SHALL have parameter PIX_W, default 8, bits per pixel; IN_W = 16, so two pixels per input beat.
REQ-004 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1, qualifies in_data; no backpressure.
REQ-007 SHALL have port in_data, input, 16, two pixels: [15:8] even column, [7:0] odd column.
REQ-008 SHALL have port mem_we, output, 1, row write strobe to the 480x5120 original-image SRAM.
REQ-009 SHALL have port mem_addr, output, 9, row index 0..IMG_H-1.
REQ-010 SHALL have port mem_din, output, IMG_W*PIX_W (5120), assembled row; column c at bits [8c+7:8c].
REQ-011 SHALL have port done, output, 1, one-cycle pulse after final row write.
REQ-012 SHALL have port frame_loaded, output, 1, level: full frame in SRAM, cleared by first beat of next frame.

Function
REQ-013 SHALL use FSM states IDLE, LOAD, DONE.
REQ-014 IDLE -> LOAD on an in_valid beat; that beat is beat 0 of row 0.
REQ-015 SHALL accept a beat in every cycle with in_valid=1 in IDLE or LOAD; gaps of any length are legal, and counters hold during gaps.
REQ-016 SHALL keep beat counter 0..IMG_W/2-1 (319) and row counter 0..IMG_H-1 (479); beat wraps 319->0 and increments row.
REQ-017 SHALL place beat b into columns 2b (in_data[15:8]) and 2b+1 (in_data[7:0]) of the row buffer.
REQ-018 On acceptance of beat 319, SHALL register mem_din = completed row (including that beat) and mem_addr = row, and assert mem_we for exactly the next cycle (latency 1).
REQ-019 mem_din/mem_addr SHALL be held in an output register separate from the row buffer, so beat 0 of row r+1 accepted in the same cycle as row r's write does not corrupt it.
REQ-020 mem_we SHALL be 0 in all other cycles; partial rows are never written.
REQ-021 After accepting beat 319 of row 479, the FSM SHALL go LOAD -> DONE; DONE lasts one cycle with done=1, coincident with the row-479 mem_we, then returns to IDLE.
REQ-022 in_valid SHALL be ignored in DONE; beats presented there are dropped.
REQ-023 frame_loaded SHALL set with done and clear on acceptance of the next frame's beat 0.
REQ-024 Row buffer contents SHALL not need clearing between rows; every column is overwritten before each write.

Reset
REQ-025 With rst=1 at a rising edge, SHALL set state IDLE, beat=0, row=0, mem_we=0, mem_addr=0, mem_din=0, done=0, frame_loaded=0.
REQ-026 Reset mid-frame SHALL discard the partial row and issue no write; the next beat after reset is row 0, beat 0.
REQ-027 rst SHALL take priority over an in_valid beat in the same cycle.

Structure
REQ-028 IMG_W, IMG_H, PIX_W, ROW_BITS (5120), BEATS_PER_ROW (320), ROW_ADDR_W (9) and FSM state encodings SHALL live in the shared SIFT parameter package used by the Gaussian and line-buffer stages.
REQ-029 SHALL be a single module; no sub-module is required.

Verification
REQ-030 Stream 153600 back-to-back beats, beat value {row[7:0], b[7:0]} -> 480 writes; write r occurs 1 cycle after its beat 319; column 2b = r[7:0], column 2b+1 = b[7:0]; done pulse with addr 479.
REQ-031 Same frame with in_valid toggling 1/0 each cycle and random 0-20 cycle stalls -> mem_din/mem_addr sequence identical to REQ-030.
REQ-032 Row 5 beat 319 followed by row 6 beat 0 (value 16'hAAAA) on the next cycle -> addr 5 write carries unmodified row 5; row 6 column 0/1 later read 8'hAA.
REQ-033 rst asserted after row 10 beat 100, then a fresh frame -> no write at addr 10 before reset; first write after reset is addr 0 with new data.
REQ-034 in_valid held high through DONE, then a second frame -> DONE-cycle beat dropped; second frame writes rows 0..479; frame_loaded 1 between frames and 0 after second frame's first beat.
REQ-035 Assertions: mem_we never high for 2 consecutive cycles without an intervening 319 beats; done only in DONE; mem_addr <= 479.

Source files
------------

// File: rtl/image_loader_pkg.sv
// Shared SIFT front-end parameters: frame geometry, row packing and loader FSM encoding.
package image_loader_pkg;

    localparam int IMG_W         = 640;
    localparam int IMG_H         = 480;
    localparam int PIX_W         = 8;
    localparam int IN_W          = 2 * PIX_W;
    localparam int ROW_BITS      = IMG_W * PIX_W;
    localparam int BEATS_PER_ROW = IMG_W / 2;
    localparam int ROW_ADDR_W    = $clog2(IMG_H);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/image_loader_if.sv
// Pixel stream in / row-write SRAM port out of the image loader.
interface image_loader_if
    import image_loader_pkg::*;
#(
    parameter int IMG_W = image_loader_pkg::IMG_W,
    parameter int IMG_H = image_loader_pkg::IMG_H,
    parameter int PIX_W = image_loader_pkg::PIX_W
);
    localparam int RBITS = IMG_W * PIX_W;
    localparam int AW    = $clog2(IMG_H);

    logic                 in_valid;
    logic [2*PIX_W-1:0]   in_data;
    logic                 mem_we;
    logic [AW-1:0]        mem_addr;
    logic [RBITS-1:0]     mem_din;
    logic                 done;
    logic                 frame_loaded;

    modport master (
        output in_valid, in_data,
        input  mem_we, mem_addr, mem_din, done, frame_loaded
    );

    modport slave (
        input  in_valid, in_data,
        output mem_we, mem_addr, mem_din, done, frame_loaded
    );

endinterface

// File: rtl/image_loader.sv
// Collects two-pixel beats into full rows and writes each completed row to the frame SRAM.
module image_loader
    import image_loader_pkg::*;
#(
    parameter int IMG_W = image_loader_pkg::IMG_W,
    parameter int IMG_H = image_loader_pkg::IMG_H,
    parameter int PIX_W = image_loader_pkg::PIX_W
) (
    input  logic          clk,
    input  logic          rst,
    image_loader_if.slave bus
);
    localparam int BPR    = IMG_W / 2;
    localparam int PAIR_W = 2 * PIX_W;
    localparam int RBITS  = IMG_W * PIX_W;
    localparam int AW     = $clog2(IMG_H);
    localparam int BW     = $clog2(BPR);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BPR - 1);
    localparam logic [AW-1:0] LAST_ROW  = AW'(IMG_H - 1);

    state_t            state_reg;
    logic [BW-1:0]     beat_reg;
    logic [AW-1:0]     row_reg;
    logic [PAIR_W-1:0] row_buf_reg [BPR];
    logic              mem_we_reg;
    logic [AW-1:0]     mem_addr_reg;
    logic [RBITS-1:0]  mem_din_reg;
    logic              done_reg;
    logic              frame_loaded_reg;

    logic              accept;
    logic              last_beat;
    logic [PAIR_W-1:0] pair_next;
    logic [RBITS-1:0]  row_next;

    assign accept    = bus.in_valid && (state_reg != S_DONE);
    assign last_beat = (beat_reg == LAST_BEAT);
    // Even column arrives in the high byte but sits at the lower bit offset of the row.
    assign pair_next = {bus.in_data[PIX_W-1:0], bus.in_data[PAIR_W-1:PIX_W]};

    // The final beat is spliced in directly so the row is complete in its acceptance cycle.
    genvar gi;
    generate
        for (gi = 0; gi < BPR - 1; gi++) begin : g_row
            assign row_next[gi*PAIR_W +: PAIR_W] = row_buf_reg[gi];
        end
    endgenerate
    assign row_next[RBITS-1 -: PAIR_W] = pair_next;

    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            row_buf_reg[beat_reg] <= pair_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= S_IDLE;
            beat_reg         <= '0;
            row_reg          <= '0;
            mem_we_reg       <= 1'b0;
            mem_addr_reg     <= '0;
            mem_din_reg      <= '0;
            done_reg         <= 1'b0;
            frame_loaded_reg <= 1'b0;
        end else begin
            mem_we_reg <= 1'b0;
            done_reg   <= 1'b0;
            case (state_reg)
                S_IDLE, S_LOAD: begin
                    if (bus.in_valid) begin
                        state_reg <= S_LOAD;
                        if (state_reg == S_IDLE) begin
                            frame_loaded_reg <= 1'b0;
                        end
                        if (last_beat) begin
                            beat_reg     <= '0;
                            mem_we_reg   <= 1'b1;
                            mem_addr_reg <= row_reg;
                            mem_din_reg  <= row_next;
                            if (row_reg == LAST_ROW) begin
                                row_reg          <= '0;
                                state_reg        <= S_DONE;
                                done_reg         <= 1'b1;
                                frame_loaded_reg <= 1'b1;
                            end else begin
                                row_reg <= row_reg + 1'b1;
                            end
                        end else begin
                            beat_reg <= beat_reg + 1'b1;
                        end
                    end
                end
                S_DONE:  state_reg <= S_IDLE;
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign bus.mem_we       = mem_we_reg;
    assign bus.mem_addr     = mem_addr_reg;
    assign bus.mem_din      = mem_din_reg;
    assign bus.done         = done_reg;
    assign bus.frame_loaded = frame_loaded_reg;

endmodule
